// File: rtl/perf_pkg.sv
// rtl/perf_pkg.sv - shared event indices and controller state encoding for the perf counter unit
package perf_pkg;

    localparam int STALL   = 0;
    localparam int FLUSH   = 1;
    localparam int RETIRE  = 2;
    localparam int BRTAKEN = 3;

    typedef enum logic [1:0] {
        ST_IDLE     = 2'd0,
        ST_RUN      = 2'd1,
        ST_CLEARING = 2'd2
    } perf_state_t;

endpackage

// File: rtl/perf_cnt_slice.sv
// rtl/perf_cnt_slice.sv - one live counter with its shadow register and sticky overflow flag
module perf_cnt_slice #(
    parameter int CNT_W    = 32,
    parameter int SATURATE = 0
) (
    input  logic             clk_i,
    input  logic             rst_i,
    input  logic             clr_i,
    input  logic             snap_i,
    input  logic             inc_i,
    output logic [CNT_W-1:0] shadow_o,
    output logic             ovf_o
);

    localparam logic [CNT_W-1:0] CNT_MAX = '1;

    logic [CNT_W-1:0] cnt_q;

    always_ff @(posedge clk_i) begin
        if (!rst_i || clr_i) begin
            cnt_q    <= '0;
            shadow_o <= '0;
            ovf_o    <= 1'b0;
        end else begin
            // shadow captures the value held before this edge's increment
            if (snap_i) begin
                shadow_o <= cnt_q;
            end
            if (inc_i) begin
                if (cnt_q == CNT_MAX) begin
                    ovf_o <= 1'b1;
                    if (SATURATE == 0) begin
                        cnt_q <= '0;
                    end
                end else begin
                    cnt_q <= cnt_q + CNT_W'(1);
                end
            end
        end
    end

endmodule

// File: rtl/perf_counter_unit.sv
// rtl/perf_counter_unit.sv - cycle and event performance counters with snapshot shadows and registered readback
module perf_counter_unit
    import perf_pkg::*;
#(
    parameter int NUM_EVT  = 4,
    parameter int CNT_W    = 32,
    parameter int SATURATE = 0
) (
    input  logic               clk_i,
    input  logic               rst_i,
    input  logic               start_i,
    input  logic [NUM_EVT-1:0] evt_i,
    input  logic [NUM_EVT-1:0] en_mask_i,
    input  logic               clr_i,
    input  logic               snap_i,
    input  logic [3:0]         rd_addr_i,
    output logic [CNT_W-1:0]   rd_data_o,
    output logic [NUM_EVT:0]   ovf_o,
    output logic               snap_valid_o
);

    perf_state_t state_q;
    perf_state_t state_d;
    logic        inc_en;
    logic [NUM_EVT:0] inc_vec;
    logic [CNT_W-1:0] shadow_tab [16];

    always_ff @(posedge clk_i) begin
        if (!rst_i) begin
            state_q <= ST_IDLE;
        end else begin
            state_q <= state_d;
        end
    end

    always_comb begin
        state_d = state_q;
        if (clr_i) begin
            state_d = ST_CLEARING;
        end else begin
            case (state_q)
                ST_IDLE:     state_d = start_i ? ST_RUN : ST_IDLE;
                ST_RUN:      state_d = start_i ? ST_RUN : ST_IDLE;
                ST_CLEARING: state_d = start_i ? ST_RUN : ST_IDLE;
                default:     state_d = ST_IDLE;
            endcase
        end
    end

    // the edge following a clear is a dead cycle for every counter
    assign inc_en  = start_i && (state_q != ST_CLEARING);
    assign inc_vec = {evt_i & en_mask_i, 1'b1} & {(NUM_EVT+1){inc_en}};

    for (genvar g = 0; g < 16; g++) begin : g_slot
        if (g <= NUM_EVT) begin : g_cnt
            perf_cnt_slice #(
                .CNT_W    (CNT_W),
                .SATURATE (SATURATE)
            ) u_slice (
                .clk_i    (clk_i),
                .rst_i    (rst_i),
                .clr_i    (clr_i),
                .snap_i   (snap_i),
                .inc_i    (inc_vec[g]),
                .shadow_o (shadow_tab[g]),
                .ovf_o    (ovf_o[g])
            );
        end else begin : g_empty
            assign shadow_tab[g] = '0;
        end
    end

    always_ff @(posedge clk_i) begin
        if (!rst_i) begin
            rd_data_o    <= '0;
            snap_valid_o <= 1'b0;
        end else begin
            rd_data_o <= shadow_tab[rd_addr_i];
            if (clr_i) begin
                snap_valid_o <= 1'b0;
            end else if (snap_i) begin
                snap_valid_o <= 1'b1;
            end
        end
    end

endmodule

// File: doc/perf_counter_unit.md
PERF_COUNTER_UNIT -- requirements
Module: perf_counter_unit

Interface
REQ-001 The block SHALL have parameter NUM_EVT, default 4, giving the number of event channels; legal range 1..15.
REQ-002 The block SHALL have parameter CNT_W, default 32, giving the counter width; legal range 8..64.
REQ-003 The block SHALL have parameter SATURATE, default 0; 1 selects saturating counters, 0 selects wrapping counters.
REQ-004 clk_i  input  1  single clock; all state updates on its rising edge.
REQ-005 rst_i  input  1  reset, synchronous and active-low.
REQ-006 start_i  input  1  global count enable, matching the CPU start_i.
REQ-007 evt_i  input  NUM_EVT  per-cycle event pulses; bit k is event k (bit 0 stall, bit 1 flush, bit 2 retire, bit 3 branch-taken).
REQ-008 en_mask_i  input  NUM_EVT  per-channel enable; 1 enables the channel.
REQ-009 clr_i  input  1  one-cycle request to zero all counters, the shadow registers and the overflow flags.
REQ-010 snap_i  input  1  one-cycle request to copy all live counters into the shadow registers.
REQ-011 rd_addr_i  input  4  read select; 0 selects the cycle counter, k (1..NUM_EVT) selects event k-1.
REQ-012 rd_data_o  output  CNT_W  selected shadow value.
REQ-013 ovf_o  output  NUM_EVT+1  sticky overflow flags; bit 0 is the cycle counter, bit k is event k-1.
REQ-014 snap_valid_o  output  1  high once any snapshot has been taken since the last reset or clear.

Function
REQ-015 The cycle counter SHALL increment by 1 on every edge where start_i=1.
REQ-016 Event counter k SHALL increment by 1 on every edge where start_i=1, en_mask_i[k]=1 and evt_i[k]=1.
REQ-017 Each counter SHALL increment by at most 1 per cycle; no counter changes while start_i=0.
REQ-018 Wrap mode (SATURATE=0): an increment from 2^CNT_W-1 SHALL give 0 and set the matching ovf_o bit.
REQ-019 Saturate mode (SATURATE=1): an increment attempted at 2^CNT_W-1 SHALL leave the counter unchanged and set the matching ovf_o bit.
REQ-020 ovf_o bits SHALL stay set until clr_i or reset.
REQ-021 snap_i SHALL load every shadow register with its live counter's pre-increment value, i.e. the value held before that edge.
REQ-022 Counting SHALL continue in the snap_i cycle; a snapshot never loses an increment.
REQ-023 When clr_i is high, it SHALL zero every live counter, every shadow register, ovf_o and snap_valid_o, and SHALL override both snap_i and any increment in the same cycle.
REQ-024 rd_data_o SHALL be registered with one-cycle latency: it shows shadow[rd_addr_i] sampled at the previous edge.
REQ-025 A snap_i and a read in the same cycle SHALL return the old shadow value; the new value is readable from the next cycle.
REQ-026 If rd_addr_i > NUM_EVT, rd_data_o SHALL be 0 on the following cycle.
REQ-027 The state machine SHALL have three states: IDLE (start_i=0), RUN (start_i=1) and CLEARING (clr_i seen).
REQ-028 State transitions: IDLE to RUN on start_i=1; RUN to IDLE on start_i=0; any state to CLEARING on clr_i=1; CLEARING returns to IDLE or RUN on the next edge according to start_i.
REQ-029 No counter SHALL increment in the first cycle after CLEARING.

Reset
REQ-030 While rst_i=0 at an edge, all counters, shadow registers, rd_data_o, ovf_o and snap_valid_o SHALL become 0 and the state SHALL become IDLE.
REQ-031 Reset in the middle of counting SHALL drop all in-flight increments and any pending snapshot.

Structure
REQ-032 Event index constants (STALL=0, FLUSH=1, RETIRE=2, BRTAKEN=3) and the state encoding SHALL live in the shared package perf_pkg.
REQ-033 One counter plus its shadow and overflow logic SHALL be the sub-module perf_cnt_slice, instantiated NUM_EVT+1 times.

Verification
REQ-034 Reset, then start_i=1 for 10 cycles, snap_i, rd_addr_i=0 -> rd_data_o=10 two cycles after snap; ovf_o=0.
REQ-035 evt_i=4'b0011 for 5 cycles with en_mask_i=4'b0001, snap -> addr1 reads 5, addr2 reads 0.
REQ-036 CNT_W=8, SATURATE=0, 300 stall events -> counter reads 44, ovf_o[1]=1; with SATURATE=1 -> reads 255, ovf_o[1]=1.
REQ-037 clr_i and snap_i in the same cycle, evt_i=4'b1111 -> all reads 0, ovf_o=0, snap_valid_o=0 next cycle; no increment in the following cycle.
REQ-038 rst_i=0 for one edge during counting with counters at 7 -> all outputs 0, state IDLE; after restart, counts resume from 0.
REQ-039 rd_addr_i=NUM_EVT+1 -> rd_data_o=0; start_i=0 with evt_i active -> no counter changes.
